// File: rtl/iq_phase_extractor.sv
`default_nettype none
// ============================================================================
// Module   : iq_phase_extractor
// Brief    : Iterative vectoring CORDIC converting an (I,Q) sample into
//            phase (binary radians) and magnitude.
// Revision : 1.0
// ============================================================================
module iq_phase_extractor #(
  parameter int NUM_BITS = 24,
  parameter int NUM_ITER = 22
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       tick_i,
  input  logic signed [NUM_BITS-1:0] sin_i,
  input  logic signed [NUM_BITS-1:0] cos_i,
  output logic signed [NUM_BITS-1:0] phase_o,
  output logic        [NUM_BITS-1:0] magnitude_o,
  output logic                       done_o
);

  localparam int  C_XW      = NUM_BITS + 2;
  localparam int  C_ZW      = NUM_BITS + 1;
  localparam int  C_IW      = $clog2(NUM_ITER);
  localparam real C_PI_REAL = 3.14159265358979323846;
  localparam logic [NUM_BITS-1:0] C_KC =
    NUM_BITS'($rtoi(0.6072529350 * (2.0 ** NUM_BITS) + 0.5));
  localparam logic signed [C_ZW-1:0] C_PI = {2'b01, {(NUM_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_SCALE  = 2'd2
  } state_t;

  // atan(2^-idx) scaled so that pi maps to 2^(NUM_BITS-1); series for idx > 0
  function automatic logic signed [C_ZW-1:0] atan_lsb(input int idx);
    real t, x2, term, acc;
    t    = 1.0 / (2.0 ** idx);
    x2   = t * t;
    term = t;
    acc  = 0.0;
    if (idx == 0) begin
      acc = C_PI_REAL / 4.0;
    end else begin
      for (int k = 0; k < 30; k++) begin
        if (k % 2 == 0) acc = acc + term / (2.0 * k + 1.0);
        else            acc = acc - term / (2.0 * k + 1.0);
        term = term * x2;
      end
    end
    return C_ZW'($rtoi(acc * (2.0 ** (NUM_BITS - 1)) / C_PI_REAL + 0.5));
  endfunction

  logic signed [C_ZW-1:0] w_atan_tab [NUM_ITER];

  for (genvar g = 0; g < NUM_ITER; g++) begin : g_atan
    assign w_atan_tab[g] = atan_lsb(g);
  end

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_accept;
  logic [C_IW-1:0]          r_iter;
  logic signed [C_XW-1:0]   r_x;
  logic signed [C_XW-1:0]   r_y;
  logic signed [C_ZW-1:0]   r_z;
  logic                     r_zero;
  logic signed [NUM_BITS-1:0] r_phase;
  logic [NUM_BITS-1:0]      r_mag;
  logic                     r_done;

  logic signed [C_XW-1:0]   w_cos_ext;
  logic signed [C_XW-1:0]   w_sin_ext;
  logic signed [C_XW-1:0]   w_x_sh;
  logic signed [C_XW-1:0]   w_y_sh;
  logic signed [C_ZW-1:0]   w_atan;
  logic [NUM_BITS:0]        w_x_mag;
  logic [2*NUM_BITS:0]      w_prod;
  logic [2*NUM_BITS:0]      w_prod_sh;
  logic [NUM_BITS-1:0]      w_mag_sat;

  assign w_cos_ext = {{2{cos_i[NUM_BITS-1]}}, cos_i};
  assign w_sin_ext = {{2{sin_i[NUM_BITS-1]}}, sin_i};
  assign w_x_sh    = r_x >>> r_iter;
  assign w_y_sh    = r_y >>> r_iter;
  assign w_atan    = w_atan_tab[r_iter];

  // x never goes negative after pre-rotation, so its sign bit is dropped
  assign w_x_mag   = r_x[C_XW-2:0];
  assign w_prod    = w_x_mag * C_KC;
  assign w_prod_sh = w_prod >> NUM_BITS;
  assign w_mag_sat = (|w_prod_sh[2*NUM_BITS:NUM_BITS]) ? '1 : w_prod_sh[NUM_BITS-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      // the done cycle still counts as busy, so a tick there is dropped
      S_IDLE: begin
        if (tick_i && !r_done) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ROTATE;
        end
      end
      S_ROTATE: begin
        if (r_iter == C_IW'(NUM_ITER - 1)) w_state_nxt = S_SCALE;
      end
      S_SCALE:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_zero  <= 1'b0;
      r_phase <= '0;
      r_mag   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_iter <= '0;
            r_zero <= (cos_i == '0) && (sin_i == '0);
            if (cos_i[NUM_BITS-1]) begin
              r_x <= -w_cos_ext;
              r_y <= -w_sin_ext;
              r_z <= sin_i[NUM_BITS-1] ? -C_PI : C_PI;
            end else begin
              r_x <= w_cos_ext;
              r_y <= w_sin_ext;
              r_z <= '0;
            end
          end
        end
        S_ROTATE: begin
          r_iter <= r_iter + C_IW'(1);
          if (!r_y[C_XW-1]) begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan;
          end
        end
        S_SCALE: begin
          // a (0,0) vector would otherwise accumulate the full atan table sum
          r_phase <= r_zero ? '0 : r_z[NUM_BITS-1:0];
          r_mag   <= w_mag_sat;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign phase_o     = r_phase;
  assign magnitude_o = r_mag;
  assign done_o      = r_done;

endmodule
`default_nettype wire
